// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, default
// parameters, bus widths and the halfword order of a fetched line.
package sram_controller_pkg;

  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned SRAM_AW_DEF     = 18;

  localparam int unsigned HW_W   = 16;  // SRAM data width
  localparam int unsigned WA_W   = 17;  // word address width
  localparam int unsigned LINE_W = 64;  // cache line width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Halfword index of the final phase of each access type
  localparam logic [1:0] WR_LAST_HW = 2'd1;
  localparam logic [1:0] RD_LAST_HW = 2'd3;

  // Line layout: even word in the upper half, each word little-halfword first
  function automatic logic [LINE_W-1:0] pack_line(input logic [HW_W-1:0] hw0,
                                                  input logic [HW_W-1:0] hw1,
                                                  input logic [HW_W-1:0] hw2,
                                                  input logic [HW_W-1:0] hw3);
    return {hw1, hw0, hw3, hw2};
  endfunction

endpackage

// File: rtl/sram_controller_phase_counter.sv
// Phase timer for SRAM accesses: counts WAIT_CYCLES clocks per halfword
// phase and advances a 2-bit halfword index at each phase boundary.
// Ports: clk, rst (sync, active low), clear (hold at zero while not busy),
//        last_cycle (final clock of the current phase), hw_index.
module sram_controller_phase_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  output logic       last_cycle,
  output logic [1:0] hw_index
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign last_cycle = (cnt == CW'(WAIT_CYCLES - 1));

  // Phase counter wraps to 0 and bumps the halfword index on the last cycle
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt      <= '0;
      hw_index <= '0;
    end else if (last_cycle) begin
      cnt      <= '0;
      hw_index <= hw_index + 2'd1;
    end else begin
      cnt      <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Bridges cache requests to a 16-bit asynchronous SRAM. A word write becomes
// two halfword write phases; a line read becomes four halfword read phases
// assembled into a 64-bit line.
// Ports: clk, rst (sync, active low); cache side address, wdata, mem_read,
//        mem_write, ready (combinational on the requests), rdata;
//        SRAM side SRAM_DQ (tristate), SRAM_ADDR, SRAM_WE_N, SRAM_OE_N,
//        SRAM_CE_N/UB_N/LB_N (tied active).
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic               ready,
  output logic [LINE_W-1:0]  rdata,
  inout  wire  [HW_W-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  state_t            state;
  state_t            state_next;
  logic [WA_W-1:0]   wa_q;
  logic [31:0]       wdata_q;
  logic              last_cycle;
  logic [1:0]        hw_index;
  logic              busy;
  logic              dq_oe;
  logic [HW_W-1:0]   dq_out;
  logic [HW_W-1:0]   hw0;
  logic [HW_W-1:0]   hw1;
  logic [HW_W-1:0]   hw2;

  assign busy = (state == WRITE) || (state == READ);

  sram_controller_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .clear      (!busy),
    .last_cycle (last_cycle),
    .hw_index   (hw_index)
  );

  // State register and request capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wa_q    <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (mem_write || mem_read)) begin
        wa_q    <= WA_W'((address - 32'(BASE_ADDR)) >> 2);
        wdata_q <= wdata;
      end
    end
  end

  // Next state and SRAM strobes
  always_comb begin
    state_next = state;
    SRAM_ADDR  = '0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    dq_oe      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write)     state_next = WRITE;
        else if (mem_read) state_next = READ;
      end
      WRITE: begin
        SRAM_ADDR = SRAM_AW'({wa_q, hw_index[0]});
        SRAM_WE_N = last_cycle;  // last phase cycle holds data with WE_N high
        dq_oe     = 1'b1;
        if (last_cycle && hw_index == WR_LAST_HW) state_next = DONE;
      end
      READ: begin
        SRAM_ADDR = SRAM_AW'({wa_q[WA_W-1:1], hw_index});
        SRAM_OE_N = 1'b0;
        if (last_cycle && hw_index == RD_LAST_HW) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready = ((state == IDLE) && !mem_read && !mem_write) || (state == DONE);

  assign dq_out  = hw_index[0] ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ = dq_oe ? dq_out : {HW_W{1'bz}};

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // Line buffer: rdata changes only when the fourth halfword arrives
  always_ff @(posedge clk) begin
    if (!rst) begin
      hw0   <= '0;
      hw1   <= '0;
      hw2   <= '0;
      rdata <= '0;
    end else if (state == READ && last_cycle) begin
      case (hw_index)
        2'd0:    hw0   <= SRAM_DQ;
        2'd1:    hw1   <= SRAM_DQ;
        2'd2:    hw2   <= SRAM_DQ;
        default: rdata <= pack_line(hw0, hw1, hw2, SRAM_DQ);
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;

  localparam int unsigned WAIT   = 2;
  localparam int unsigned BASE   = 1024;
  localparam int          WR_LAT = 2 * WAIT + 1;
  localparam int          RD_LAT = 4 * WAIT + 1;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic [31:0] address   = '0;
  logic [31:0] wdata     = '0;
  logic        mem_read  = 1'b0;
  logic        mem_write = 1'b0;
  logic        ready;
  logic [63:0] rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  sram_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT),
    .SRAM_AW     (18)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ready     (ready),
    .rdata     (rdata),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_OE_N (oe_n),
    .SRAM_CE_N (ce_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM plus a probe driver used to prove the bus is released
  logic [15:0] sram [0:262143] = '{default: 16'h0000};
  logic        probe_en  = 1'b0;
  logic [15:0] probe_val = 16'h0000;
  assign sram_dq = (!oe_n && we_n) ? sram[sram_addr] : 16'hzzzz;
  assign sram_dq = probe_en ? probe_val : 16'hzzzz;
  always @(posedge clk) if (!we_n) sram[sram_addr] <= sram_dq;

  // Strobe activity monitor
  int          we_lo = 0;
  int          oe_lo = 0;
  logic [17:0] rd_addrs [$];
  always @(negedge clk) begin
    if (!we_n) we_lo <= we_lo + 1;
    if (!oe_n) oe_lo <= oe_lo + 1;
    if (!oe_n && (rd_addrs.size() == 0 || rd_addrs[rd_addrs.size()-1] != sram_addr))
      rd_addrs.push_back(sram_addr);
  end

  // Reference model: halfword-addressed memory
  logic [15:0] ref_mem [int unsigned];
  logic [63:0] last_rd = '0;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) % 131072;
  endfunction

  function automatic logic [15:0] ref_hw(input int unsigned i);
    return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
  endfunction

  function automatic logic [63:0] ref_line(input logic [31:0] a);
    int unsigned lb;
    lb = (word_of(a) / 2) * 4;
    return {ref_hw(lb + 1), ref_hw(lb), ref_hw(lb + 3), ref_hw(lb + 2)};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
    int unsigned wi;
    wi = word_of(a);
    ref_mem[2 * wi]     = d[15:0];
    ref_mem[2 * wi + 1] = d[31:16];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for ready, counting cycles from the request's IDLE cycle
  task automatic wait_ready(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 50);
  endtask

  task automatic do_op(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int exp_lat, input logic [63:0] exp_rd);
    int we0, oe0, q0, lat;
    int unsigned wi, lb;
    we0 = we_lo; oe0 = oe_lo; q0 = rd_addrs.size();
    wi = word_of(a);
    lb = (wi / 2) * 4;
    address = a; wdata = d; mem_write = w; mem_read = !w;
    wait_ready(lat);
    mem_write = 1'b0; mem_read = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rdata"}, rdata, exp_rd);
    check({tag, " we_n low cycles"}, 64'(we_lo - we0), w ? 64'd2 : 64'd0);
    check({tag, " oe_n low cycles"}, 64'(oe_lo - oe0), w ? 64'd0 : 64'd8);
    if (w) begin
      check({tag, " sram lo"}, 64'(sram[2 * wi]), 64'(d[15:0]));
      check({tag, " sram hi"}, 64'(sram[2 * wi + 1]), 64'(d[31:16]));
      ref_write(a, d);
    end else begin
      check({tag, " addr steps"}, 64'(rd_addrs.size() - q0), 64'd4);
      if (rd_addrs.size() >= q0 + 4)
        for (int k = 0; k < 4; k++)
          check({tag, " addr seq"}, 64'(rd_addrs[q0 + k]), 64'((lb + k) % 262144));
    end
    last_rd = exp_rd;
    @(posedge clk); #1;
    check({tag, " idle ready"}, 64'(ready), 64'd1);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic [63:0] rd;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [6];
    int          lat, lat2, we0, seen;
    logic [31:0] a, d;
    logic        w;

    vecs[0] = '{1'b1, 32'd1032, 32'hDEADBEEF, WR_LAT, 64'h0};
    vecs[1] = '{1'b1, 32'd1036, 32'h12345678, WR_LAT, 64'h0};
    vecs[2] = '{1'b0, 32'd1036, 32'h0,        RD_LAT, 64'hDEADBEEF_12345678};
    vecs[3] = '{1'b1, 32'd1024, 32'hCAFEF00D, WR_LAT, 64'hDEADBEEF_12345678};
    vecs[4] = '{1'b0, 32'd1028, 32'h0,        RD_LAT, 64'hCAFEF00D_00000000};
    vecs[5] = '{1'b0, 32'd1032, 32'h0,        RD_LAT, 64'hDEADBEEF_12345678};

    // Reset held with no request
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset we_n", 64'(we_n), 64'd1);
    check("reset oe_n", 64'(oe_n), 64'd1);
    check("reset addr", 64'(sram_addr), 64'd0);
    check("reset rdata", rdata, 64'd0);
    check("tied enables", 64'({ce_n, ub_n, lb_n}), 64'd0);
    probe_en = 1'b1; probe_val = 16'hA5C3;
    #1;
    check("reset dq released", 64'(sram_dq), 64'hA5C3);
    probe_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // Table-driven writes and line reads
    for (int i = 0; i < 6; i++)
      do_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].rd);

    // Simultaneous requests: write first, then the held read
    we0 = we_lo;
    address = 32'd1024; wdata = 32'h11112222; mem_write = 1'b1; mem_read = 1'b1;
    wait_ready(lat);
    check("both write latency", 64'(lat), 64'(WR_LAT));
    mem_write = 1'b0;
    ref_write(32'd1024, 32'h11112222);
    wait_ready(lat2);
    check("both read latency", 64'(lat2), 64'(RD_LAT + 1));
    check("both read rdata", rdata, ref_line(32'd1024));
    check("both single write", 64'(we_lo - we0), 64'd2);
    mem_read = 1'b0;
    last_rd = rdata;
    @(posedge clk); #1;

    // Reset in the middle of a read
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    address = 32'd1036; mem_read = 1'b1; seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) seen = 1;
    end
    check("abort in read", 64'(oe_n), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort oe_n", 64'(oe_n), 64'd1);
    check("abort we_n", 64'(we_n), 64'd1);
    check("abort no ready", 64'(ready), 64'd0);
    check("abort no early ready", 64'(seen), 64'd0);
    check("abort rdata", rdata, 64'd0);
    check("abort addr", 64'(sram_addr), 64'd0);
    mem_read = 1'b0;
    #1;
    check("abort idle ready", 64'(ready), 64'd1);
    rst = 1'b1;
    last_rd = 64'd0;
    @(posedge clk); #1;

    // Back-to-back writes
    we0 = we_lo;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      do_op($sformatf("b2b%0d", i), 1'b1, 32'(BASE + 4 * i), d, WR_LAT, last_rd);
    end
    check("b2b write strobes", 64'(we_lo - we0), 64'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("b2b sram%0d", i), 64'(sram[i]), 64'(ref_hw(i)));

    // Randomized traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'(BASE - 32 + $urandom_range(0, 127));
      d = $urandom;
      do_op($sformatf("rnd%0d", i), w, a, d, w ? WR_LAT : RD_LAT, w ? last_rd : ref_line(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
